l2_write_buffer: RTL and testbench
==================================

// Module: l2_write_buffer
// PURPOSE
//  Posted-write buffer between the L2 cache's physical-memory port and physical memory.
//  L2 write-backs are acknowledged in one cycle and drained to memory when the port is idle.
//  L2 reads are answered from the buffer on a line hit, otherwise forwarded to memory.
//  Removes write-back latency from the L2 miss path.
// PARAMETERS
//  DEPTH  4  number of line entries; power of two, >= 2
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    synchronous active-low reset
//  up_read      in   1    L2 read request; held until up_resp
//  up_write     in   1    L2 write-back request; held until up_resp
//  up_address   in   16   L2 line address (lc3b_word); bits [3:0] ignored
//  up_wdata     in   128  write-back line (lc3b_burst)
//  up_resp      out  1    one-cycle completion pulse to L2
//  up_rdata     out  128  read line; valid while up_resp=1
//  pmem_resp    in   1    memory completion pulse
//  pmem_rdata   in   128  memory read line; valid with pmem_resp
//  pmem_read    out  1    memory read request
//  pmem_write   out  1    memory write request
//  pmem_address out  16   {tag,4'b0}
//  pmem_wdata   out  128  line being drained
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset synchronous, active-low (rst_n), sampled on the rising edge.
//  Reset values: state=IDLE, count=0, head/tail=0, all valid=0;
//   up_resp=0, pmem_read=0, pmem_write=0, up_rdata=0, pmem_address=0.
//  Outputs are Moore-decoded from registered state and latched regs.
//  Entry = {valid, tag[11:0]=address[15:4], data[127:0]}.
//  Circular FIFO: head, tail wrap mod DEPTH; count 0..DEPTH; full=(count==DEPTH).
//  Match: tag compared against all valid entries. Coalescing keeps tags unique, so at most one hit.
//  States:
//   IDLE
//    - up_write & hit: overwrite the matching entry's data -> RESP
//    - up_write & !hit & !full: enqueue at tail -> RESP
//    - up_write & !hit & full: -> DRAIN; write accepted after the pop, not in the DRAIN cycle
//    - up_read & hit: latch entry data -> RESP
//    - up_read & miss: latch address -> RD_MEM
//    - no request & count>0: -> DRAIN
//    - else stay IDLE
//   RD_MEM: pmem_read=1, pmem_address=latched; on pmem_resp latch pmem_rdata -> RESP
//   DRAIN: pmem_write=1, address/data from head; on pmem_resp pop head (valid=0, count--) -> IDLE
//   RESP: up_resp=1 for exactly one cycle -> IDLE. L2 deasserts its request that edge; IDLE resamples.
//  Priority: any upstream request beats drain when not full. An in-flight memory op is never aborted.
//  Read misses may bypass buffered writes; no address conflict exists because a hit is served locally.
//  Latency:
//   - write accept / read hit: request in IDLE at cycle 0 -> up_resp at cycle 1
//   - read miss: up_resp one cycle after pmem_resp
//   - full write: up_resp one cycle after the IDLE re-entry following drain pmem_resp
//  up_read & up_write both high: illegal; write wins; simulation assertion fires.
//  Reset mid-operation: buffered lines discarded, memory transaction abandoned, IDLE next cycle.
//  Drain order strictly FIFO by first insertion; a coalesced entry keeps its slot.
// STRUCTURE
//  lc3b_types: add
//   - typedef logic [11:0] lc3b_line_tag
//   - enum wb_state_t {IDLE, RD_MEM, DRAIN, RESP}
//  Sub-module wb_entry_array holds DEPTH entries, pointers, count and parallel tag match.
//   Outputs: hit, hit_idx, full, empty, head entry. Inputs: write/merge/pop strobes.
//  Top contains the FSM and output latches only.
// TESTING
//  1 reset; write 0x1230 D0 -> up_resp @+1, no pmem op that cycle; idle -> pmem_write addr 0x1230 data D0, count->0
//  2 write 0x1230 D0, then write 0x1238 D1 before drain -> count=1; a single pmem_write carries D1
//  3 write 0x2000 D2, read 0x2004 -> up_rdata=D2, up_resp @+1, pmem_read never asserted
//  4 memory stalls; writes 0x1000,0x2000,0x3000,0x4000; 5th write 0x5000
//    -> drain 0x1000 first; up_resp only after that pmem_resp; count=4 after
//  5 buffer holds 0x1000; read 0x6000 -> pmem_read 0x6000 before any pmem_write;
//    up_rdata=pmem_rdata @ pmem_resp+1; 0x1000 drained afterwards
//  6 rst_n=0 during DRAIN -> next cycle pmem_write=0, up_resp=0, count=0; following read 0x1000 misses to memory

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line widths, line tag and write-buffer FSM states.
// No logic, no latency.
// No flow control; types only.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;
    typedef logic [11:0]  lc3b_line_tag;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_MEM = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } wb_state_t;

    // Line tag is the address with the 16-byte line offset stripped.
    function automatic lc3b_line_tag line_tag(input lc3b_word addr);
        return addr[15:4];
    endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Circular store of buffered write-back lines with a parallel tag match on all valid entries.
// Match is combinational; push/merge/pop take effect on the next rising edge.
// No internal backpressure: the owner must not push when full nor pop when empty.
module wb_entry_array
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [11:0]              lookup_tag,
    input  logic [127:0]             wr_data,
    input  logic                     push,
    input  logic                     merge,
    input  logic [$clog2(DEPTH)-1:0] merge_idx,
    input  logic                     pop,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] hit_idx,
    output logic [127:0]             hit_data,
    output logic                     full,
    output logic                     empty,
    output logic [11:0]              head_tag,
    output logic [127:0]             head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid;
    lc3b_line_tag     tag_q  [DEPTH];
    lc3b_burst        data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    // Tag compare against every valid entry; coalescing keeps tags unique so at most one hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag_q[i] == lookup_tag)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign hit_data  = data_q[hit_idx];
    assign head_tag  = tag_q[head];
    assign head_data = data_q[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

    // Occupancy bookkeeping: valid bits, pointers and count; reset discards all lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
                count       <= count + CW'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
                count       <= count - CW'(1);
            end
        end
    end

    // Line storage: push fills the tail slot, merge overwrites a hit in place so it keeps its drain slot.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[tail]  <= lookup_tag;
            data_q[tail] <= wr_data;
        end
        if (merge) begin
            data_q[merge_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/l2_write_buffer.sv
// Posted-write buffer between L2 and memory: absorbs write-backs, serves read hits, drains when idle.
// Write accept / read hit: up_resp one cycle after request; read miss: one cycle after pmem_resp.
// L2 holds its request until up_resp; a write to a full buffer waits for one drain to complete.
module l2_write_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_read,
    input  logic         up_write,
    input  logic [15:0]  up_address,
    input  logic [127:0] up_wdata,
    output logic         up_resp,
    output logic [127:0] up_rdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata
);

    localparam int PW = $clog2(DEPTH);

    wb_state_t     state;
    wb_state_t     state_nxt;
    lc3b_line_tag  up_tag;
    lc3b_line_tag  rd_tag_q;
    lc3b_burst     rdata_q;

    logic          hit;
    logic [PW-1:0] hit_idx;
    lc3b_burst     hit_data;
    logic          full;
    logic          empty;
    lc3b_line_tag  head_tag;
    lc3b_burst     head_data;

    logic          push;
    logic          merge;
    logic          pop;
    logic          lat_hit;
    logic          lat_miss;
    logic          lat_mem;

    assign up_tag = line_tag(up_address);

    wb_entry_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (up_tag),
        .wr_data    (up_wdata),
        .push       (push),
        .merge      (merge),
        .merge_idx  (hit_idx),
        .pop        (pop),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_data   (hit_data),
        .full       (full),
        .empty      (empty),
        .head_tag   (head_tag),
        .head_data  (head_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: upstream requests beat draining unless a write finds the buffer full.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (up_write) begin
                    state_nxt = (hit || !full) ? RESP : DRAIN;
                end else if (up_read) begin
                    state_nxt = hit ? RESP : RD_MEM;
                end else if (!empty) begin
                    state_nxt = DRAIN;
                end
            end
            RD_MEM:  if (pmem_resp) state_nxt = RESP;
            DRAIN:   if (pmem_resp) state_nxt = IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore port decode plus the one-cycle array and latch strobes.
    always_comb begin
        up_resp      = (state == RESP);
        pmem_read    = (state == RD_MEM);
        pmem_write   = (state == DRAIN);
        pmem_address = '0;
        if (state == RD_MEM) begin
            pmem_address = {rd_tag_q, 4'h0};
        end else if (state == DRAIN) begin
            pmem_address = {head_tag, 4'h0};
        end
        merge    = (state == IDLE) && up_write && hit;
        push     = (state == IDLE) && up_write && !hit && !full;
        pop      = (state == DRAIN) && pmem_resp;
        lat_hit  = (state == IDLE) && !up_write && up_read && hit;
        lat_miss = (state == IDLE) && !up_write && up_read && !hit;
        lat_mem  = (state == RD_MEM) && pmem_resp;
    end

    assign up_rdata   = rdata_q;
    assign pmem_wdata = head_data;

    // Read-path latches: hit line or memory line for up_rdata, miss tag for the memory request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rd_tag_q <= '0;
        end else begin
            if (lat_hit) rdata_q <= hit_data;
            if (lat_mem) rdata_q <= pmem_rdata;
            if (lat_miss) rd_tag_q <= up_tag;
        end
    end

    // Simultaneous read and write is an L2 protocol error; the write is served.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(up_read && up_write));
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
module tb_l2_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         up_read;
    logic         up_write;
    logic [15:0]  up_address;
    logic [127:0] up_wdata;
    logic         up_resp;
    logic [127:0] up_rdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [127:0] D0 = {4{32'h00D0_1230}};
    localparam logic [127:0] D1 = {4{32'h00D1_1238}};
    localparam logic [127:0] D2 = {4{32'h00D2_2000}};
    localparam logic [127:0] DA = {4{32'hAAAA_1000}};
    localparam logic [127:0] DB = {4{32'hBBBB_1000}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_write_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_read      (up_read),
        .up_write     (up_write),
        .up_address   (up_address),
        .up_wdata     (up_wdata),
        .up_resp      (up_resp),
        .up_rdata     (up_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic         is_wr;
        logic [15:0]  addr;
        logic [127:0] data;
        int           cyc;
    } mem_op_t;

    mem_op_t      log_q[$];
    logic         mem_auto  = 1'b0;
    logic         mem_stall = 1'b0;
    int           mem_lat   = 0;
    logic         mem_resp  = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         tbl_resp  = 1'b0;

    assign pmem_resp  = mem_auto ? mem_resp : tbl_resp;
    assign pmem_rdata = mem_auto ? mem_rdata : '0;

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        return {8{a ^ 16'h5a5a}};
    endfunction

    initial begin : mem_model
        int wait_cnt;
        mem_op_t op;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mem_auto || !rst_n) begin
                mem_resp = 1'b0;
                wait_cnt = 0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
            end else if ((pmem_read || pmem_write) && !mem_stall) begin
                if (wait_cnt >= mem_lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_line(pmem_address);
                    op.is_wr  = pmem_write;
                    op.addr   = pmem_address;
                    op.data   = pmem_wdata;
                    op.cyc    = cyc;
                    log_q.push_back(op);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- table vectors ----------------
    typedef struct {
        logic         rst_n;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic         presp;
        logic         e_resp;
        logic         e_rd;
        logic         e_wr;
        logic [15:0]  e_addr;
        logic         e_chk_wdata;
        logic [127:0] e_wdata;
        logic         e_chk_rdata;
        logic [127:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic r, input logic rd, input logic wr, input logic [15:0] a,
                           input logic [127:0] wd, input logic pr, input logic er, input logic erd,
                           input logic ewr, input logic [15:0] ea, input logic cw,
                           input logic [127:0] ew, input logic cr, input logic [127:0] erdat);
        vec_t v;
        v.rst_n = r; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.presp = pr;
        v.e_resp = er; v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea;
        v.e_chk_wdata = cw; v.e_wdata = ew; v.e_chk_rdata = cr; v.e_rdata = erdat;
        tbl.push_back(v);
    endtask

    // ---------------- request helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic l2_req(input logic wr, input logic [15:0] addr, input logic [127:0] data,
                          output int lat, output logic [127:0] rdata, output int resp_cyc);
        up_write   = wr;
        up_read    = !wr;
        up_address = addr;
        up_wdata   = data;
        lat        = 0;
        rdata      = '0;
        resp_cyc   = -1;
        while (1) begin
            step();
            lat++;
            if (up_resp) begin
                rdata    = up_rdata;
                resp_cyc = cyc;
                break;
            end
            if (lat >= 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_timeout addr=%h: got no up_resp, expected up_resp within 500 cycles", addr);
                break;
            end
        end
        up_write = 1'b0;
        up_read  = 1'b0;
        step();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (log_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_timeout: got %0d memory ops, expected %0d", log_q.size(), n);
        end
    endtask

    // ---------------- main ----------------
    int           lat;
    int           rc;
    logic [127:0] rdat;

    initial begin
        rst_n = 1'b0; up_read = 1'b0; up_write = 1'b0; up_address = '0; up_wdata = '0;

        //       rst rd wr addr     wdata presp resp rd wr eaddr    cw ewdata cr erdata
        add_vec(0, 0, 0, 16'h0000, '0, 0,   0, 0, 0, 16'h0000, 0, '0, 1, '0);
        add_vec(1, 0, 1, 16'h1230, D0, 0,   1, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 1, 16'h1230, 1, D0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 1,   0, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 1, 16'h2000, D2, 0,   1, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 1, 0, 16'h2004, '0, 0,   1, 0, 0, 16'h0000, 0, '0, 1, D2);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 1, 16'h2000, 1, D2, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 1,   0, 0, 0, 16'h0000, 0, '0, 0, '0);
        add_vec(1, 0, 0, 16'h0000, '0, 0,   0, 0, 0, 16'h0000, 0, '0, 0, '0);

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n      = tbl[i].rst_n;
            up_read    = tbl[i].rd;
            up_write   = tbl[i].wr;
            up_address = tbl[i].addr;
            up_wdata   = tbl[i].wdata;
            tbl_resp   = tbl[i].presp;
            step();
            check($sformatf("v%0d up_resp", i), up_resp, tbl[i].e_resp);
            check($sformatf("v%0d pmem_read", i), pmem_read, tbl[i].e_rd);
            check($sformatf("v%0d pmem_write", i), pmem_write, tbl[i].e_wr);
            if (tbl[i].e_rd || tbl[i].e_wr)
                check($sformatf("v%0d pmem_address", i), pmem_address, tbl[i].e_addr);
            if (tbl[i].e_chk_wdata)
                check($sformatf("v%0d pmem_wdata", i), pmem_wdata, tbl[i].e_wdata);
            if (tbl[i].e_chk_rdata)
                check($sformatf("v%0d up_rdata", i), up_rdata, tbl[i].e_rdata);
        end
        up_read = 1'b0; up_write = 1'b0; tbl_resp = 1'b0;
        mem_auto = 1'b1;
        idle(2);

        // Coalescing: two writes to one line leave one entry carrying the newer data.
        log_q.delete();
        l2_req(1'b1, 16'h1230, D0, lat, rdat, rc);
        check("coal_lat0", lat, 1);
        l2_req(1'b1, 16'h1238, D1, lat, rdat, rc);
        check("coal_lat1", lat, 1);
        wait_log(1, 50);
        idle(10);
        check("coal_nops", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check("coal_is_wr", log_q[0].is_wr, 1'b1);
            check("coal_addr", log_q[0].addr, 16'h1230);
            check("coal_data", log_q[0].data, D1);
        end

        // Full buffer with a stalled memory: fifth write waits behind the oldest drain.
        log_q.delete();
        mem_stall = 1'b1;
        mem_lat   = 0;
        for (int i = 1; i <= 4; i++) begin
            l2_req(1'b1, 16'(i * 16'h1000), {8{16'(i * 16'h1111)}}, lat, rdat, rc);
            check($sformatf("full_lat%0d", i), lat, 1);
        end
        fork
            l2_req(1'b1, 16'h5000, {8{16'h5555}}, lat, rdat, rc);
            begin
                repeat (6) @(posedge clk);
                mem_stall = 1'b0;
            end
        join
        check("full_lat5_waited", lat > 6, 1'b1);
        if (log_q.size() >= 1) begin
            check("full_first_addr", log_q[0].addr, 16'h1000);
            check("full_first_data", log_q[0].data, {8{16'h1111}});
            check("full_resp_cyc", rc, log_q[0].cyc + 2);
        end else begin
            check("full_first_op", log_q.size(), 1);
        end
        wait_log(5, 100);
        idle(5);
        check("full_nops", log_q.size(), 5);
        for (int i = 1; i < 5; i++) begin
            if (i < log_q.size())
                check($sformatf("full_order%0d", i), log_q[i].addr, 16'((i + 1) * 16'h1000));
        end

        // Read miss bypasses a buffered write.
        log_q.delete();
        mem_lat = 3;
        l2_req(1'b1, 16'h1000, DA, lat, rdat, rc);
        l2_req(1'b0, 16'h6000, '0, lat, rdat, rc);
        check("miss_rdata", rdat, mem_line(16'h6000));
        wait_log(2, 100);
        if (log_q.size() >= 2) begin
            check("miss_first_is_rd", log_q[0].is_wr, 1'b0);
            check("miss_first_addr", log_q[0].addr, 16'h6000);
            check("miss_resp_cyc", rc, log_q[0].cyc + 1);
            check("miss_then_wr", log_q[1].is_wr, 1'b1);
            check("miss_then_addr", log_q[1].addr, 16'h1000);
            check("miss_then_data", log_q[1].data, DA);
        end

        // Reset during a drain discards the buffer.
        log_q.delete();
        mem_lat   = 0;
        mem_stall = 1'b1;
        l2_req(1'b1, 16'h1000, DB, lat, rdat, rc);
        idle(2);
        check("rst_pre_drain", pmem_write, 1'b1);
        rst_n = 1'b0;
        step();
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_up_resp", up_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        idle(3);
        check("rst_no_drain", pmem_write, 1'b0);
        l2_req(1'b0, 16'h1000, '0, lat, rdat, rc);
        check("rst_miss_rdata", rdat, mem_line(16'h1000));
        idle(5);
        check("rst_nops", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check("rst_op_is_rd", log_q[0].is_wr, 1'b0);
            check("rst_op_addr", log_q[0].addr, 16'h1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
